// File: rtl/encode_tx_sched.sv
// encode_tx_sched: arbitrates encode-zero and scan-command sync words onto one serial_tx.
// Optional idle heartbeat word is built in when ENCODE_TX_HEARTBEAT_EN is defined.
module encode_tx_sched #(
    parameter int DATA_WIDTH   = 16,
    parameter int GAP_CYCLES   = 8,
    parameter int BUSY_TIMEOUT = 64
`ifdef ENCODE_TX_HEARTBEAT_EN
    , parameter int HEARTBEAT_PERIOD = 4096
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  encode_zero_req_i,
    input  logic                  scan_cmd_req_i,
    input  logic [1:0]            scan_cmd_sel_i,
    input  logic                  tx_busy_i,
    output logic                  tx_valid_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  scan_cmd_ack_o,
    output logic                  scan_cmd_err_o,
    output logic                  scan_active_o,
    output logic                  scan_test_o,
    output logic                  tx_timeout_o,
    output logic [15:0]           encode_drop_cnt_o,
    output logic [2:0]            state_o
);
    // Handshake: tx_valid_o is a one-cycle load strobe with tx_data_o; serial_tx
    // accepts by raising tx_busy_i and finishes by dropping it. No ready is sampled.
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DATA_WIDTH-1:0] ENC_WORD = DATA_WIDTH'(16'hECDE);
    localparam logic [DATA_WIDTH-1:0] HB_WORD  = DATA_WIDTH'(16'h5A5F);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    typedef enum logic [1:0] {K_ENC = 2'd0, K_SCAN = 2'd1, K_HB = 2'd2} kind_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    enc_pend_q, cmd_pend_q, hb_pend;
    logic [1:0]              cmd_sel_q, word_sel_q;
    kind_t                   kind_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [15:0]             drop_cnt_q;
    logic                    ack_q, err_q, active_q, test_q;
    logic                    any_pend, start, enc_take, cmd_take, cmd_ok, scan_done;

    function automatic logic [DATA_WIDTH-1:0] scan_word(input logic [1:0] sel);
        case (sel)
            2'd0:    scan_word = DATA_WIDTH'(16'h5A51);
            2'd1:    scan_word = DATA_WIDTH'(16'h5A53);
            default: scan_word = DATA_WIDTH'(16'h5A50);
        endcase
    endfunction

    // A pending is consumed on the IDLE cycle that launches LOAD; fixed priority.
    assign any_pend  = enc_pend_q | cmd_pend_q | hb_pend;
    assign start     = (state_q == ST_IDLE) && any_pend;
    assign enc_take  = start && enc_pend_q;
    assign cmd_take  = start && !enc_pend_q && cmd_pend_q;
    assign cmd_ok    = scan_cmd_req_i && (scan_cmd_sel_i != 2'd3) && (!cmd_pend_q || cmd_take);
    assign scan_done = (state_q == ST_WAIT_DONE) && !tx_busy_i && (kind_q == K_SCAN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (any_pend) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy_i)                              state_d = ST_WAIT_DONE;
                else if (cnt_q == CNT_W'(BUSY_TIMEOUT))     state_d = ST_GAP;
            end
            ST_WAIT_DONE: if (!tx_busy_i) state_d = ST_GAP;
            ST_GAP:       if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o   = (state_q == ST_LOAD);
        tx_timeout_o = (state_q == ST_WAIT_BUSY) && !tx_busy_i && (cnt_q == CNT_W'(BUSY_TIMEOUT));
    end

    // cnt_q counts cycles since LOAD (busy timeout) and cycles spent in GAP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_d == ST_LOAD && state_q != ST_LOAD) ||
                     (state_d == ST_GAP && state_q != ST_GAP)) begin
            cnt_q <= '0;
        end else if (state_q inside {ST_LOAD, ST_WAIT_BUSY, ST_GAP}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enc_pend_q <= 1'b0;
            cmd_pend_q <= 1'b0;
            cmd_sel_q  <= 2'd0;
            drop_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            if (encode_zero_req_i)  enc_pend_q <= 1'b1;
            else if (enc_take)      enc_pend_q <= 1'b0;
            if (encode_zero_req_i && enc_pend_q && !enc_take && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
            if (cmd_ok) begin
                cmd_pend_q <= 1'b1;
                cmd_sel_q  <= scan_cmd_sel_i;
            end else if (cmd_take) begin
                cmd_pend_q <= 1'b0;
            end
            err_q <= scan_cmd_req_i && !cmd_ok;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q     <= '0;
            kind_q     <= K_ENC;
            word_sel_q <= 2'd0;
        end else if (start) begin
            if (enc_pend_q) begin
                data_q <= ENC_WORD;
                kind_q <= K_ENC;
            end else if (cmd_pend_q) begin
                data_q     <= scan_word(cmd_sel_q);
                kind_q     <= K_SCAN;
                word_sel_q <= cmd_sel_q;
            end else begin
                data_q <= HB_WORD;
                kind_q <= K_HB;
            end
        end
    end

    // Flags follow completed words only, mirroring the far-end decoder.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            active_q <= 1'b0;
            test_q   <= 1'b0;
        end else begin
            ack_q <= scan_done;
            if (scan_done) begin
                case (word_sel_q)
                    2'd0:    begin active_q <= 1'b1; test_q <= 1'b0; end
                    2'd1:    begin active_q <= 1'b1; test_q <= 1'b1; end
                    default: active_q <= 1'b0;
                endcase
            end
        end
    end

`ifdef ENCODE_TX_HEARTBEAT_EN
    localparam int IDLE_W = $clog2(HEARTBEAT_PERIOD + 1);
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              hb_pend_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt_q <= '0;
            hb_pend_q  <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                idle_cnt_q <= '0;
            end else if (state_q == ST_IDLE && !any_pend) begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                if (idle_cnt_q == IDLE_W'(HEARTBEAT_PERIOD - 1)) hb_pend_q <= 1'b1;
            end
            if (start && !enc_pend_q && !cmd_pend_q) hb_pend_q <= 1'b0;
        end
    end
    assign hb_pend = hb_pend_q;
`else
    assign hb_pend = 1'b0;
`endif

    assign tx_data_o         = data_q;
    assign scan_cmd_ack_o    = ack_q;
    assign scan_cmd_err_o    = err_q;
    assign scan_active_o     = active_q;
    assign scan_test_o       = test_q;
    assign encode_drop_cnt_o = drop_cnt_q;
    assign state_o           = state_q;
endmodule
